// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage defaults and the queued entry layout.
package fetch_pkg;
  localparam int FETCH_PC_W = 8;
  localparam int FETCH_INSTR_W = 16;
  localparam int FETCH_DEPTH = 4;
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, push, pop and entry count.
module fetch_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage: PC/issue logic feeding a prefetch queue toward decode.
module fetch_buffer_stage
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH = FETCH_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pcWrEn,
  input  logic [PC_W-1:0]          newPc,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_data,
  output logic [INSTR_W-1:0]       instruction,
  output logic [PC_W-1:0]          instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } entry_t;
  logic [PC_W-1:0] pc, inflight_pc;
  logic inflight, issue;
  entry_t head;
  // Count the in-flight fetch against capacity so its push always finds space.
  assign issue = !pcWrEn && (occupancy + CW'(inflight)) < CW'(DEPTH);
  assign imem_addr = pc;
  assign instr_valid = occupancy != '0;
  assign instruction = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (pcWrEn) begin
      pc <= newPc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + 1'b1;
        inflight_pc <= pc;
      end
    end
  end
  fetch_fifo #(.W(INSTR_W + PC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (reset | pcWrEn),
    .push  (inflight && !pcWrEn),
    .pop   (instr_valid && instr_ready && !pcWrEn),
    .din   ({imem_data, inflight_pc}),
    .dout  (head),
    .count (occupancy)
  );
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// tb_fetch_buffer_stage: directed checks of fetch_buffer_stage against a 1-cycle ROM.
module tb_fetch_buffer_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pcWrEn = 1'b0;
  logic [7:0] newPc = '0;
  logic [7:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic [15:0] instruction;
  logic [7:0] instr_pc;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic [2:0] occupancy;
  int vectors = 0;
  int miscompares = 0;

  fetch_buffer_stage dut (
    .clk(clk), .reset(reset), .pcWrEn(pcWrEn), .newPc(newPc),
    .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    return a == 8'h00 ? 16'h1234 : a == 8'h01 ? 16'h1008 : a == 8'h02 ? 16'h2222 :
           a == 8'h10 ? 16'h7007 : a == 8'hFF ? 16'hABCD : {8'hEE, a};
  endfunction

  always @(posedge clk) imem_data <= rom(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pcWrEn = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pcWrEn = 1'b1;
    newPc = 8'h55;
    instr_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({instr_valid, occupancy, instruction, instr_pc, imem_addr} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b occ=%0d ins=%h pc=%h addr=%h want all zero",
               instr_valid, occupancy, instruction, instr_pc, imem_addr);
    end
    pcWrEn = 1'b0;
  endtask

  task automatic test_fill_stream();
    do_reset();
    instr_ready = 1'b1;
    step();
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_edge1 got valid=%b want 0", instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({instr_valid, instruction, instr_pc} !== {1'b1, rom(8'(k)), 8'(k)}) begin
        miscompares++;
        $display("FAIL fill_stream[%0d] got v=%b ins=%h pc=%h want 1 %h %h",
                 k, instr_valid, instruction, instr_pc, rom(8'(k)), 8'(k));
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    vectors++;
    if ({occupancy, imem_addr, instruction, instr_pc} !== {3'd4, 8'h04, 16'h1234, 8'h00}) begin
      miscompares++;
      $display("FAIL saturate got occ=%0d addr=%h ins=%h pc=%h want 4 04 1234 00",
               occupancy, imem_addr, instruction, instr_pc);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if ({instr_valid, instruction, instr_pc} !== {1'b1, rom(8'(k)), 8'(k)}) begin
        miscompares++;
        $display("FAIL drain[%0d] got v=%b ins=%h pc=%h want 1 %h %h",
                 k, instr_valid, instruction, instr_pc, rom(8'(k)), 8'(k));
      end
      step();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    pcWrEn = 1'b1;
    newPc = 8'h10;
    step();
    pcWrEn = 1'b0;
    vectors++;
    if ({instr_valid, occupancy, imem_addr} !== {1'b0, 3'd0, 8'h10}) begin
      miscompares++;
      $display("FAIL redirect_flush got v=%b occ=%0d addr=%h want 0 0 10",
               instr_valid, occupancy, imem_addr);
    end
    step();
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_gap got valid=%b want 0", instr_valid);
    end
    step();
    vectors++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h7007, 8'h10}) begin
      miscompares++;
      $display("FAIL redirect_first got v=%b ins=%h pc=%h want 1 7007 10",
               instr_valid, instruction, instr_pc);
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    pcWrEn = 1'b1;
    newPc = 8'hFF;
    step();
    pcWrEn = 1'b0;
    step();
    step();
    vectors++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'hABCD, 8'hFF}) begin
      miscompares++;
      $display("FAIL wrap_ff got v=%b ins=%h pc=%h want 1 abcd ff", instr_valid, instruction, instr_pc);
    end
    step();
    vectors++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h1234, 8'h00}) begin
      miscompares++;
      $display("FAIL wrap_00 got v=%b ins=%h pc=%h want 1 1234 00", instr_valid, instruction, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) step();
    vectors++;
    if (occupancy !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_prefill got occ=%0d want 3", occupancy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    vectors++;
    if ({instr_valid, occupancy, imem_addr} !== {1'b0, 3'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b occ=%0d addr=%h want 0 0 00", instr_valid, occupancy, imem_addr);
    end
    step();
    vectors++;
    if ({instr_valid, occupancy} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL mid_stale got v=%b occ=%0d want 0 0", instr_valid, occupancy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({instr_valid, instruction, instr_pc, occupancy} !== {1'b1, rom(8'(k)), 8'(k), 3'd1}) begin
        miscompares++;
        $display("FAIL mid_restream[%0d] got v=%b ins=%h pc=%h occ=%0d want 1 %h %h 1",
                 k, instr_valid, instruction, instr_pc, occupancy, rom(8'(k)), 8'(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    pcWrEn = 1'b1;
    newPc = 8'h10;
    step();
    vectors++;
    if (imem_addr !== 8'h10) begin
      miscompares++;
      $display("FAIL b2b_first got addr=%h want 10", imem_addr);
    end
    newPc = 8'h02;
    step();
    pcWrEn = 1'b0;
    vectors++;
    if ({instr_valid, imem_addr} !== {1'b0, 8'h02}) begin
      miscompares++;
      $display("FAIL b2b_second got v=%b addr=%h want 0 02", instr_valid, imem_addr);
    end
    step();
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap got valid=%b want 0", instr_valid);
    end
    for (int k = 2; k < 5; k++) begin
      step();
      vectors++;
      if ({instr_valid, instruction, instr_pc} !== {1'b1, rom(8'(k)), 8'(k)}) begin
        miscompares++;
        $display("FAIL b2b_stream[%0d] got v=%b ins=%h pc=%h want 1 %h %h",
                 k, instr_valid, instruction, instr_pc, rom(8'(k)), 8'(k));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_stream();
    test_saturate();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
